program_loader: RTL and testbench
=================================

# program_loader

Sequential writer for the instruction memory. Accepts a byte stream (word count header, then big-endian 32-bit instruction words), assembles each word and issues one-cycle write strobes with byte addresses into the program memory's write port. Holds the processor in reset while loading; releases it when the program is complete. It is the write-side counterpart of the combinational, word-aligned instruction read path.

## Interface
- MEMORY_DEPTH, 32, number of 32-bit words in program memory
- DATA_WIDTH, 32, instruction/address width

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Start  input  1  one-cycle pulse; begins a load (honoured in IDLE, DONE and ERROR only)
- ByteIn  input  8  stream byte
- ByteValid  input  1  ByteIn valid this cycle
- ByteReady  output  1  loader accepts a byte this cycle; transfer when ByteValid & ByteReady
- WriteEnable  output  1  one-cycle write strobe to program memory
- WriteAddress  output  DATA_WIDTH  byte address, always a multiple of 4
- WriteData  output  DATA_WIDTH  assembled instruction
- CpuHold  output  1  high while loading; processor held in reset
- Done  output  1  high once a load completed successfully, until next Start
- Error  output  1  high after an oversized header, until next Start

## Operation
- States: IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE, ERROR.
- IDLE: ByteReady=0, CpuHold=0. Start -> CNT_HI; clears word index, byte index, Done, Error.
- CNT_HI: accepts count[15:8]. CNT_LO: accepts count[7:0].
  - count==0 -> DONE, no writes.
  - count>MEMORY_DEPTH -> ERROR, no writes.
  - else -> DATA.
- DATA: accepts 4 bytes per word, first byte -> bits [31:24], last -> [7:0]. After the 4th byte -> WRITE.
- WRITE (1 cycle): WriteEnable=1, WriteAddress={word_index,2'b00}, WriteData=assembled word, ByteReady=0. word_index increments. If word_index+1==count -> DONE, else -> DATA.
- DONE: Done=1, CpuHold=0. ERROR: Error=1, CpuHold=1 (processor stays held). Both wait for Start; bytes are ignored (ByteReady=0).
- CpuHold=1 in CNT_HI, CNT_LO, DATA, WRITE, ERROR.
- ByteReady=1 only in CNT_HI, CNT_LO, DATA.
- Start while loading (CNT_HI..WRITE) is ignored.
- Counters: byte index 2 bits, wraps 3->0 on the 4th byte; word index wide enough for MEMORY_DEPTH, never exceeds count-1 when used as an address.

## Timing
- Reset (reset=0, async): state IDLE, ByteReady=0, WriteEnable=0, WriteAddress=0, WriteData=0, CpuHold=0, Done=0, Error=0, all counters 0.
- Reset mid-load: immediate abort, no further strobes; memory retains words already written.
- All outputs registered or decoded from state registers only; no combinational path from ByteValid/ByteIn to outputs.
- Start at edge N -> ByteReady=1 from cycle N+1.
- 4th data byte accepted at edge N -> WriteEnable high during cycle N+1, exactly one cycle; ByteReady=0 in that cycle; next byte is acceptable at edge N+2.
- Throughput: 5 cycles per word when ByteValid is held high.
- After the last WRITE cycle, Done=1 and CpuHold=0 from the next cycle.
- ByteValid gaps: state holds; partial word and counters are preserved indefinitely.

## Test plan
- Reset then Start, stream 00 02 | 24 08 00 05 | 00 00 00 0C with ByteValid constant -> two strobes: addr 0x0 data 0x24080005, then addr 0x4 data 0x0000000C; Done=1, CpuHold=0 afterwards.
- Header 00 00 -> no WriteEnable, Done=1 one cycle after the 2nd byte.
- MEMORY_DEPTH=32, header 00 21 (33) -> Error=1, CpuHold=1, no writes; subsequent bytes not accepted; new Start clears Error.
- Header 00 20, 32 words with random ByteValid gaps -> 32 strobes, addresses 0x00..0x7C in order, data matches; last address 0x7C.
- Assert reset after 2 of 3 words -> all outputs at reset values asynchronously, no third strobe; new Start reloads from address 0.
- Start pulsed during DATA -> ignored; load completes normally with correct addresses.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: takes a 16-bit word count and then big-endian 32-bit words,
// and writes them into the instruction memory. The processor is held in reset while loading.
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  CpuHold,
    output logic                  Done,
    output logic                  Error
);

    localparam int IW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [16:0] DEPTH_L = 17'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t state, next_state;

    logic [7:0]            count_hi;
    logic [15:0]           count;
    logic [15:0]           lo_count;
    logic [1:0]            byte_idx;
    logic [IW-1:0]         word_idx;
    logic [DATA_WIDTH-1:0] word;
    logic [16:0]           word_next;
    logic                  last_word;
    logic                  start_ok;

    assign lo_count  = {count_hi, ByteIn};
    assign word_next = 17'(word_idx) + 17'd1;
    assign last_word = (word_next == {1'b0, count});
    assign start_ok  = Start && (state == IDLE || state == DONE || state == ERROR);

    // Address and data come straight from registers; the index only moves after the strobe.
    assign WriteAddress = DATA_WIDTH'({word_idx, 2'b00});
    assign WriteData    = word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        ByteReady   = 1'b0;
        WriteEnable = 1'b0;
        CpuHold     = 1'b0;
        Done        = 1'b0;
        Error       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) next_state = CNT_HI;
            end
            CNT_HI: begin
                ByteReady = 1'b1;
                CpuHold   = 1'b1;
                if (ByteValid) next_state = CNT_LO;
            end
            CNT_LO: begin
                ByteReady = 1'b1;
                CpuHold   = 1'b1;
                if (ByteValid) begin
                    if (lo_count == 16'd0)                  next_state = DONE;
                    else if ({1'b0, lo_count} > DEPTH_L)    next_state = ERROR;
                    else                                    next_state = DATA;
                end
            end
            DATA: begin
                ByteReady = 1'b1;
                CpuHold   = 1'b1;
                if (ByteValid && byte_idx == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                WriteEnable = 1'b1;
                CpuHold     = 1'b1;
                next_state  = last_word ? DONE : DATA;
            end
            DONE: begin
                Done = 1'b1;
                if (Start) next_state = CNT_HI;
            end
            ERROR: begin
                Error   = 1'b1;
                CpuHold = 1'b1;
                if (Start) next_state = CNT_HI;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_hi <= '0;
            count    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            word     <= '0;
        end else begin
            if (start_ok) begin
                byte_idx <= '0;
                word_idx <= '0;
            end
            if (ByteValid && ByteReady) begin
                case (state)
                    CNT_HI: count_hi <= ByteIn;
                    CNT_LO: count    <= lo_count;
                    DATA: begin
                        word     <= {word[DATA_WIDTH-9:0], ByteIn};
                        byte_idx <= byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (state == WRITE) word_idx <= word_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized word streams
// compared against a simple list-of-writes reference model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    logic [31:0] wd [64];
    logic [31:0] obs_addr [$];
    logic [31:0] obs_data [$];
    int unsigned obs_cyc  [$];

    program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .Start(Start),
        .ByteIn(ByteIn),
        .ByteValid(ByteValid),
        .ByteReady(ByteReady),
        .WriteEnable(WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData(WriteData),
        .CpuHold(CpuHold),
        .Done(Done),
        .Error(Error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (WriteEnable === 1'b1) begin
            obs_addr.push_back(WriteAddress);
            obs_data.push_back(WriteData);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    // Caller sits at a negedge; returns at the negedge right after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
        int unsigned g;
        int unsigned w;
        g = (gap_max != 0) ? $urandom_range(gap_max, 0) : 0;
        ByteValid = 1'b0;
        repeat (g) @(negedge clk);
        ByteValid = 1'b1;
        ByteIn    = b;
        w = 0;
        while (ByteReady !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            tests++;
            fails++;
            $error("FAIL byte_accept_timeout observed=%0d expected=<50", w);
        end
        @(negedge clk);
        ByteValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input int unsigned gap_max);
        for (int i = 3; i >= 0; i--) send_byte(v[i*8 +: 8], gap_max);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic fill_random(input int unsigned n);
        for (int i = 0; i < 64; i++) wd[i] = (i < int'(n)) ? $urandom : 32'h0;
    endtask

    // Reference model: a valid load of n words writes wd[i] to byte address 4*i, in order.
    task automatic expect_writes(input string tag, input int unsigned n);
        check({tag, "_count"}, obs_addr.size(), n);
        for (int i = 0; i < int'(n) && i < obs_addr.size(); i++) begin
            check({tag, "_addr"}, obs_addr[i], 32'(i * 4));
            check({tag, "_data"}, obs_data[i], wd[i]);
        end
    endtask

    task automatic run_load(input string tag, input int unsigned n, input int unsigned gap_max);
        clear_obs();
        fill_random(n);
        pulse_start();
        check({tag, "_ready_after_start"}, ByteReady, 1'b1);
        send_byte(8'(n >> 8), gap_max);
        send_byte(8'(n), gap_max);
        for (int i = 0; i < int'(n); i++) send_word(wd[i], gap_max);
        check({tag, "_last_strobe"}, WriteEnable, 1'b1);
        @(negedge clk);
        check({tag, "_done"}, Done, 1'b1);
        check({tag, "_hold_released"}, CpuHold, 1'b0);
        expect_writes(tag, n);
    endtask

    initial begin
        reset     = 1'b0;
        Start     = 1'b0;
        ByteIn    = 8'h00;
        ByteValid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ByteReady, 1'b0);
        check("rst_we", WriteEnable, 1'b0);
        check("rst_addr", WriteAddress, 32'h0);
        check("rst_data", WriteData, 32'h0);
        check("rst_hold", CpuHold, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_error", Error, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", ByteReady, 1'b0);

        // Fixed two-word program, ByteValid held high throughout.
        clear_obs();
        wd[0] = 32'h2408_0005;
        wd[1] = 32'h0000_000C;
        pulse_start();
        check("t1_ready_after_start", ByteReady, 1'b1);
        check("t1_hold", CpuHold, 1'b1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(wd[0], 0);
        check("t1_we_cycle", WriteEnable, 1'b1);
        check("t1_ready_in_write", ByteReady, 1'b0);
        send_word(wd[1], 0);
        check("t1_last_we", WriteEnable, 1'b1);
        @(negedge clk);
        check("t1_done", Done, 1'b1);
        check("t1_hold_released", CpuHold, 1'b0);
        check("t1_we_single", WriteEnable, 1'b0);
        expect_writes("t1", 2);
        if (obs_cyc.size() == 2) check("t1_throughput", obs_cyc[1] - obs_cyc[0], 5);

        // Zero-length program.
        clear_obs();
        pulse_start();
        check("t2_done_cleared", Done, 1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t2_done", Done, 1'b1);
        check("t2_hold", CpuHold, 1'b0);
        check("t2_no_writes", obs_addr.size(), 0);

        // Oversized header (33 > 32).
        clear_obs();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h21, 0);
        check("t3_error", Error, 1'b1);
        check("t3_hold", CpuHold, 1'b1);
        check("t3_done", Done, 1'b0);
        ByteValid = 1'b1;
        ByteIn    = 8'hA5;
        repeat (5) @(negedge clk);
        check("t3_not_ready", ByteReady, 1'b0);
        check("t3_no_writes", obs_addr.size(), 0);
        ByteValid = 1'b0;
        pulse_start();
        check("t3_error_cleared", Error, 1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t3_recover_done", Done, 1'b1);

        // Full memory with random valid gaps, then a few random sizes.
        run_load("t4", 32, 3);
        if (obs_addr.size() == 32) check("t4_last_addr", obs_addr[31], 32'h7C);
        for (int k = 0; k < 3; k++) run_load("t5", $urandom_range(32, 1), 2);

        // Reset in the middle of the third word.
        clear_obs();
        fill_random(3);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(wd[0], 1);
        send_word(wd[1], 1);
        for (int i = 3; i >= 1; i--) send_byte(wd[2][i*8 +: 8], 0);
        ByteValid = 1'b1;
        ByteIn    = wd[2][7:0];
        #2 reset = 1'b0;
        #1;
        check("t6_async_ready", ByteReady, 1'b0);
        check("t6_async_we", WriteEnable, 1'b0);
        check("t6_async_addr", WriteAddress, 32'h0);
        check("t6_async_data", WriteData, 32'h0);
        check("t6_async_hold", CpuHold, 1'b0);
        check("t6_async_done", Done, 1'b0);
        check("t6_async_error", Error, 1'b0);
        repeat (3) @(negedge clk);
        ByteValid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_writes_before_abort", obs_addr.size(), 2);
        run_load("t6_reload", 1, 0);

        // Start pulsed mid-load must not disturb the transfer.
        clear_obs();
        fill_random(3);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(wd[0], 0);
        send_byte(wd[1][31:24], 0);
        pulse_start();
        check("t7_hold_kept", CpuHold, 1'b1);
        check("t7_not_done", Done, 1'b0);
        for (int i = 2; i >= 0; i--) send_byte(wd[1][i*8 +: 8], 0);
        send_word(wd[2], 1);
        @(negedge clk);
        check("t7_done", Done, 1'b1);
        expect_writes("t7", 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
